// File: rtl/gpio_pkg.sv
// Shared register offsets for the GPIO port bank.
// Each port occupies one REG_STRIDE-byte window; offsets 5-7 are reserved.
package gpio_pkg;

  localparam logic [2:0] REG_DATA  = 3'd0;
  localparam logic [2:0] REG_DDR   = 3'd1;
  localparam logic [2:0] REG_IMASK = 3'd2;
  localparam logic [2:0] REG_IFLAG = 3'd3;
  localparam logic [2:0] REG_IEDGE = 3'd4;

  localparam int REG_STRIDE = 8;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser for one port, plus a one-cycle history register.
// rise/fall compare the synchronised value against the previous cycle's value.
module gpio_sync_edge #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         cpu_clk,
  input  logic         reset,
  input  logic [W-1:0] pin,
  output logic [W-1:0] s,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain [SYNC_STAGES];
  logic [W-1:0] prev;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/gpio_port_bank.sv
// Multi-port GPIO on the CPU bus: output latch, direction, synchronised read-back
// and per-bit edge interrupt flags with mask, aggregated onto irq.
module gpio_port_bank
  import gpio_pkg::*;
#(
  parameter int  NUM_PORTS   = 2,
  parameter int  PORT_W      = 8,
  parameter int  SYNC_STAGES = 2,
  localparam int AW          = $clog2(NUM_PORTS) + 3
) (
  input  logic                        cpu_clk,
  input  logic                        reset,
  input  logic                        sel,
  input  logic                        we,
  input  logic [AW-1:0]               addr,
  input  logic [7:0]                  wdata,
  output logic [7:0]                  rdata,
  input  logic [NUM_PORTS*PORT_W-1:0] pin_in,
  output logic [NUM_PORTS*PORT_W-1:0] pin_out,
  output logic [NUM_PORTS*PORT_W-1:0] pin_oe,
  output logic                        irq
);

  localparam int OFFS_W  = $clog2(REG_STRIDE);
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [AW-1:0]     port_idx;
  logic [2:0]        offset;
  logic              wr_en;
  logic [ARM_W-1:0]  arm_cnt;
  logic              armed;
  logic [PORT_W-1:0] rd_port [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend;

  assign port_idx = addr >> OFFS_W;
  assign offset   = addr[2:0];
  assign wr_en    = sel & we;

  // Edges are ignored until the sync chain has filled with real pad samples.
  assign armed = (arm_cnt == ARM_W'(ARM_MAX));

  always_ff @(posedge cpu_clk) begin
    if (reset)       arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [PORT_W-1:0] out_q, ddr_q, imask_q, iflag_q, iedge_q;
    logic [PORT_W-1:0] s, rise, fall, edge_set, w1c, rd_val;
    logic              hit;

    gpio_sync_edge #(.W(PORT_W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .cpu_clk (cpu_clk),
      .reset   (reset),
      .pin     (pin_in[p*PORT_W +: PORT_W]),
      .s       (s),
      .rise    (rise),
      .fall    (fall)
    );

    assign hit      = wr_en && (port_idx == AW'(p));
    assign edge_set = ~ddr_q & ((iedge_q & rise) | (~iedge_q & fall)) & {PORT_W{armed}};
    assign w1c      = (hit && offset == REG_IFLAG) ? wdata[PORT_W-1:0] : '0;

    always_ff @(posedge cpu_clk) begin
      if (reset) begin
        out_q   <= '0;
        ddr_q   <= '0;
        imask_q <= '0;
        iflag_q <= '0;
        iedge_q <= '0;
      end else begin
        if (hit) begin
          case (offset)
            REG_DATA:  out_q   <= wdata[PORT_W-1:0];
            REG_DDR:   ddr_q   <= wdata[PORT_W-1:0];
            REG_IMASK: imask_q <= wdata[PORT_W-1:0];
            REG_IEDGE: iedge_q <= wdata[PORT_W-1:0];
            default:   ;
          endcase
        end
        // A new edge overrides a same-cycle clear so it is never lost.
        iflag_q <= (iflag_q & ~w1c) | edge_set;
      end
    end

    always_comb begin
      rd_val = '0;
      case (offset)
        REG_DATA:  rd_val = (ddr_q & out_q) | (~ddr_q & s);
        REG_DDR:   rd_val = ddr_q;
        REG_IMASK: rd_val = imask_q;
        REG_IFLAG: rd_val = iflag_q;
        REG_IEDGE: rd_val = iedge_q;
        default:   rd_val = '0;
      endcase
    end

    assign rd_port[p]                   = rd_val;
    assign pin_out[p*PORT_W +: PORT_W]  = out_q;
    assign pin_oe[p*PORT_W +: PORT_W]   = ddr_q;
    assign pend[p]                      = |(iflag_q & imask_q);
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_idx == AW'(p)) rdata = 8'(rd_port[p]);
      end
    end
  end

  assign irq = |pend;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed and randomized checks of gpio_port_bank against a cycle-level model
// built from the register map and the pin-to-flag timing rules.
`timescale 1ns/1ps
module tb_gpio_port_bank;

  localparam int NP = 2;
  localparam int SS = 2;

  logic        cpu_clk = 1'b0;
  logic        reset, sel, we;
  logic [3:0]  addr;
  logic [7:0]  wdata, rdata;
  logic [15:0] pin_in, pin_out, pin_oe;
  logic        irq;

  logic        sel3, we3;
  logic [4:0]  addr3;
  logic [7:0]  rdata3;
  logic [23:0] pin3, pin_out3, pin_oe3;
  logic        irq3;

  int checks, failures;

  always #20 cpu_clk = ~cpu_clk;

  gpio_port_bank #(.NUM_PORTS(2), .PORT_W(8), .SYNC_STAGES(SS)) u_dut (
    .cpu_clk(cpu_clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .pin_in(pin_in), .pin_out(pin_out),
    .pin_oe(pin_oe), .irq(irq)
  );

  gpio_port_bank #(.NUM_PORTS(3), .PORT_W(8), .SYNC_STAGES(SS)) u_dut3 (
    .cpu_clk(cpu_clk), .reset(reset), .sel(sel3), .we(we3), .addr(addr3),
    .wdata(wdata), .rdata(rdata3), .pin_in(pin3), .pin_out(pin_out3),
    .pin_oe(pin_oe3), .irq(irq3)
  );

  // Model state: registers per port, recent pin samples (index 0 = newest), cycles since reset.
  logic [7:0] m_out [NP], m_ddr [NP], m_imask [NP], m_iflag [NP], m_iedge [NP];
  logic [7:0] m_samp [NP][SS+1];
  int         m_since;

  task automatic model_step();
    logic [7:0] cur, old, clr, setb;
    bit armed;
    int idx;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        m_out[p] = 0; m_ddr[p] = 0; m_imask[p] = 0; m_iflag[p] = 0; m_iedge[p] = 0;
        for (int k = 0; k <= SS; k++) m_samp[p][k] = 0;
      end
      m_since = 0;
    end else begin
      armed = (m_since >= SS + 1);
      idx = int'(addr) / 8;
      for (int p = 0; p < NP; p++) begin
        cur = m_samp[p][SS-1];
        old = m_samp[p][SS];
        setb = 0;
        clr = 0;
        for (int b = 0; b < 8; b++)
          if (armed && !m_ddr[p][b] && cur[b] != old[b] && cur[b] == m_iedge[p][b]) setb[b] = 1;
        if (sel && we && idx == p) begin
          case (addr[2:0])
            3'd0: m_out[p] = wdata;
            3'd1: m_ddr[p] = wdata;
            3'd2: m_imask[p] = wdata;
            3'd3: clr = wdata;
            3'd4: m_iedge[p] = wdata;
            default: ;
          endcase
        end
        for (int b = 0; b < 8; b++) begin
          if (setb[b]) m_iflag[p][b] = 1;
          else if (clr[b]) m_iflag[p][b] = 0;
        end
        for (int k = SS; k > 0; k--) m_samp[p][k] = m_samp[p][k-1];
        m_samp[p][0] = pin_in[p*8 +: 8];
      end
      if (m_since < 1000) m_since++;
    end
  endtask

  function automatic logic [7:0] m_read(logic s_, logic [3:0] a);
    logic [7:0] v;
    int idx;
    idx = int'(a) / 8;
    v = 0;
    if (!s_ || idx >= NP) return 8'h00;
    case (a[2:0])
      3'd0: for (int b = 0; b < 8; b++) v[b] = m_ddr[idx][b] ? m_out[idx][b] : m_samp[idx][SS-1][b];
      3'd1: v = m_ddr[idx];
      3'd2: v = m_imask[idx];
      3'd3: v = m_iflag[idx];
      3'd4: v = m_iedge[idx];
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic m_irq();
    for (int p = 0; p < NP; p++)
      for (int b = 0; b < 8; b++)
        if (m_iflag[p][b] && m_imask[p][b]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge cpu_clk);
    model_step();
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    cyc();
    sel = 0; we = 0;
  endtask

  task automatic rd(string tag, logic [3:0] a, logic [7:0] exp);
    sel = 1; we = 0; addr = a;
    #1;
    chk(tag, rdata, exp);
    sel = 0;
  endtask

  task automatic wr3(logic [4:0] a, logic [7:0] d);
    sel3 = 1; we3 = 1; addr3 = a; wdata = d;
    cyc();
    sel3 = 0; we3 = 0;
  endtask

  task automatic rd3(string tag, logic [4:0] a, logic [7:0] exp);
    sel3 = 1; we3 = 0; addr3 = a;
    #1;
    chk(tag, rdata3, exp);
    sel3 = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, "_pin_out"}, pin_out, {m_out[1], m_out[0]});
    chk({tag, "_pin_oe"}, pin_oe, {m_ddr[1], m_ddr[0]});
    chk({tag, "_irq"}, irq, m_irq());
    for (int a = 0; a < 16; a++)
      rd($sformatf("%s_rd%0d", tag, a), 4'(a), m_read(1'b1, 4'(a)));
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1; sel = 0; we = 0; addr = 0; wdata = 0; pin_in = 16'hFFFF;
    sel3 = 0; we3 = 0; addr3 = 0; pin3 = 24'h0;
    repeat (3) cyc();
    reset = 0;
    // Rising-edge mode set while the chain is still filling from the high pads.
    wr(4'h4, 8'hFF);
    wr(4'hC, 8'hFF);
    repeat (4) cyc();
    rd("arm_iflag0", 4'h3, 8'h00);
    rd("arm_iflag1", 4'hB, 8'h00);
    check_all("arm");

    pin_in = 16'h0000;
    reset = 1; cyc(); cyc(); reset = 0; cyc();
    for (int a = 0; a < 5; a++) rd($sformatf("rst_p0_off%0d", a), 4'(a), 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_pin_oe", pin_oe, 16'h0000);
    chk("rst_pin_out", pin_out, 16'h0000);
    rd("rst_nosel", 4'h0, 8'h00);
    repeat (4) cyc();

    wr(4'h1, 8'h0F);
    wr(4'h0, 8'hA5);
    chk("t2_pin_out", pin_out[7:0], 8'hA5);
    chk("t2_pin_oe", pin_oe[7:0], 8'h0F);
    pin_in = 16'h0030;
    cyc();
    rd("t2_data_early", 4'h0, 8'h05);
    cyc();
    rd("t2_data", 4'h0, 8'h35);

    wr(4'h4, 8'h80);
    wr(4'h2, 8'h80);
    pin_in = 16'h00B0;
    cyc(); cyc();
    rd("t3_iflag_early", 4'h3, 8'h00);
    chk("t3_irq_early", irq, 1'b0);
    cyc();
    rd("t3_iflag", 4'h3, 8'h80);
    chk("t3_irq", irq, 1'b1);
    wr(4'h3, 8'h80);
    rd("t3_iflag_clr", 4'h3, 8'h00);
    chk("t3_irq_clr", irq, 1'b0);

    pin_in = 16'h00A0;
    cyc(); cyc();
    wr(4'h3, 8'h10);
    rd("t4_set_wins", 4'h3, 8'h10);
    chk("t4_irq_masked", irq, 1'b0);
    check_all("t4");

    wr(4'h9, 8'hFF);
    wr(4'h8, 8'h3C);
    chk("t5_p1_out", pin_out[15:8], 8'h3C);
    chk("t5_p0_out", pin_out[7:0], 8'hA5);
    chk("t5_oe", pin_oe, 16'hFF0F);
    wr(4'h5, 8'hFF);
    rd("t5_reserved", 4'h5, 8'h00);
    check_all("t5");

    wr3(5'h19, 8'hFF);
    wr3(5'h18, 8'h77);
    chk("t5_np3_idx3_oe", pin_oe3, 24'h000000);
    chk("t5_np3_idx3_out", pin_out3, 24'h000000);
    rd3("t5_np3_rd_idx3", 5'h19, 8'h00);
    wr3(5'h11, 8'hFF);
    wr3(5'h10, 8'h5A);
    chk("t5_np3_idx2_oe", pin_oe3, 24'hFF0000);
    chk("t5_np3_idx2_out", pin_out3, 24'h5A0000);
    rd3("t5_np3_rd_idx2", 5'h11, 8'hFF);

    chk("t6_irq_masked", irq, 1'b0);
    wr(4'h2, 8'h90);
    chk("t6_irq_unmask", irq, 1'b1);
    rd("t6_iflag_pending", 4'h3, 8'h10);
    reset = 1; cyc(); reset = 0;
    chk("t6_irq_reset", irq, 1'b0);
    rd("t6_iflag_reset", 4'h3, 8'h00);
    chk("t6_pin_out_reset", pin_out, 16'h0000);
    check_all("t6");

    for (int it = 0; it < 400; it++) begin
      reset = (($urandom % 80) == 0);
      if (($urandom % 3) == 0) pin_in = pin_in ^ 16'(1 << ($urandom % 16));
      sel = (($urandom % 4) != 0);
      we = (($urandom % 3) == 0);
      addr = 4'($urandom);
      wdata = 8'($urandom);
      cyc();
      we = 0;
      reset = 0;
      chk("rnd_pin_out", pin_out, {m_out[1], m_out[0]});
      chk("rnd_pin_oe", pin_oe, {m_ddr[1], m_ddr[0]});
      chk("rnd_irq", irq, m_irq());
      chk("rnd_rdata", rdata, m_read(sel, addr));
      sel = 0;
      if ((it % 50) == 49) check_all("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
